// File: rtl/sw_debounce_if.sv
// Switch conditioning bus: raw pins in, debounced vector and edge events out.
// With SW_DEBOUNCE_CHG_CNT_EN defined the bus also carries the 16-bit change counter.
interface sw_debounce_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_out;
    logic             sw_changed;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
`ifdef SW_DEBOUNCE_CHG_CNT_EN
    logic [15:0]      chg_cnt;

    modport master (
        output sw_raw,
        input  sw_out,
        input  sw_changed,
        input  sw_rise,
        input  sw_fall,
        input  chg_cnt
    );

    modport slave (
        input  sw_raw,
        output sw_out,
        output sw_changed,
        output sw_rise,
        output sw_fall,
        output chg_cnt
    );
`else
    modport master (
        output sw_raw,
        input  sw_out,
        input  sw_changed,
        input  sw_rise,
        input  sw_fall
    );

    modport slave (
        input  sw_raw,
        output sw_out,
        output sw_changed,
        output sw_rise,
        output sw_fall
    );
`endif
endinterface

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus per-bit stability counter for the slide switches.
// Optional SW_DEBOUNCE_CHG_CNT_EN adds a wrapping count of debounced change events.
module sw_debounce #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         rst,
    sw_debounce_if.slave bus
);
    localparam int               CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q,   sync1_d;
    logic [WIDTH-1:0] sync2_q,   sync2_d;
    logic [WIDTH-1:0] sw_out_q,  sw_out_d;
    logic [WIDTH-1:0] rise_q,    rise_d;
    logic [WIDTH-1:0] fall_q,    fall_d;
    logic             changed_q, changed_d;

    always_comb begin
        sync1_d = bus.sw_raw;
        sync2_d = sync1_q;
    end

    // Each bit owns a counter that only runs while the synchronised input
    // disagrees with the output; any agreement throws the partial count away.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             out_d;

        always_comb begin
            cnt_d = '0;
            out_d = sw_out_q[gi];
            if (sync2_q[gi] != sw_out_q[gi]) begin
                if (cnt_q == CNT_MAX) begin
                    out_d = sync2_q[gi];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign sw_out_d[gi] = out_d;
    end

    // Events are computed from the next output so they line up with the
    // first cycle sw_out shows the new value.
    always_comb begin
        rise_d    = sw_out_d & ~sw_out_q;
        fall_d    = ~sw_out_d & sw_out_q;
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            sw_out_q  <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sw_out_q  <= sw_out_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign bus.sw_out     = sw_out_q;
    assign bus.sw_rise    = rise_q;
    assign bus.sw_fall    = fall_q;
    assign bus.sw_changed = changed_q;

`ifdef SW_DEBOUNCE_CHG_CNT_EN
    logic [15:0] chg_cnt_q, chg_cnt_d;

    // Counts change events, not changed bits; wraps naturally at 16 bits.
    always_comb begin
        chg_cnt_d = chg_cnt_q + {15'd0, changed_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chg_cnt_q <= '0;
        end else begin
            chg_cnt_q <= chg_cnt_d;
        end
    end

    assign bus.chg_cnt = chg_cnt_q;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with STABLE_CYCLES=4; expected values are hand-computed edge numbers.
module tb_sw_debounce;
    localparam int W  = 8;
    localparam int SC = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    sw_debounce_if #(.WIDTH(W)) bus ();

    sw_debounce #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Packed view {changed, fall, rise, out} so one comparison covers all outputs.
    function automatic logic [31:0] snap();
        return {7'd0, bus.sw_changed, bus.sw_fall, bus.sw_rise, bus.sw_out};
    endfunction

    function automatic logic [31:0] ev(input logic [7:0] o, input logic [7:0] r,
                                       input logic [7:0] f, input logic c);
        return {7'd0, c, f, r, o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a new raw value just after an edge and expect one clean update
    // six edges later; before that the old output holds.
    task automatic settle(input string tag, input logic [7:0] raw, input logic [7:0] old_o,
                          input logic [7:0] r, input logic [7:0] f);
        bus.sw_raw = raw;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 6)       chk($sformatf("%s_e%0d", tag, k), snap(), ev(old_o, 8'h00, 8'h00, 1'b0));
            else if (k == 6) chk($sformatf("%s_e%0d", tag, k), snap(), ev(raw, r, f, 1'b1));
            else             chk($sformatf("%s_e%0d", tag, k), snap(), ev(raw, 8'h00, 8'h00, 1'b0));
        end
        $display("txn %s raw=%h out=%h", tag, raw, bus.sw_out);
    endtask

    initial begin
        rst        = 1'b1;
        bus.sw_raw = 8'h00;
        repeat (3) tick();
        chk("reset_state", snap(), ev(8'h00, 8'h00, 8'h00, 1'b0));
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("idle_c%0d", k), snap(), ev(8'h00, 8'h00, 8'h00, 1'b0));
        end
        $display("txn idle out=%h", bus.sw_out);

        // First rise of bit 7: output and pulse exactly at edge 6.
        bus.sw_raw = 8'h80;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k < 6)       chk($sformatf("rise80_e%0d", k), snap(), ev(8'h00, 8'h00, 8'h00, 1'b0));
            else if (k == 6) chk($sformatf("rise80_e%0d", k), snap(), ev(8'h80, 8'h80, 8'h00, 1'b1));
            else             chk($sformatf("rise80_e%0d", k), snap(), ev(8'h80, 8'h00, 8'h00, 1'b0));
        end
        $display("txn rise80 out=%h", bus.sw_out);

        // 3-cycle glitch on bit 0 is one short of the count and is rejected.
        bus.sw_raw = 8'h81;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 3) bus.sw_raw = 8'h80;
            chk($sformatf("glitch3_c%0d", k), snap(), ev(8'h80, 8'h00, 8'h00, 1'b0));
        end
        $display("txn glitch3 out=%h", bus.sw_out);

        // 4-cycle pulse just qualifies: rise at edge 6, fall at edge 10.
        bus.sw_raw = 8'h81;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 4) bus.sw_raw = 8'h80;
            if (k < 6)       chk($sformatf("pulse4_e%0d", k), snap(), ev(8'h80, 8'h00, 8'h00, 1'b0));
            else if (k == 6) chk($sformatf("pulse4_e%0d", k), snap(), ev(8'h81, 8'h01, 8'h00, 1'b1));
            else if (k < 10) chk($sformatf("pulse4_e%0d", k), snap(), ev(8'h81, 8'h00, 8'h00, 1'b0));
            else if (k == 10) chk($sformatf("pulse4_e%0d", k), snap(), ev(8'h80, 8'h00, 8'h01, 1'b1));
            else             chk($sformatf("pulse4_e%0d", k), snap(), ev(8'h80, 8'h00, 8'h00, 1'b0));
        end
        $display("txn pulse4 out=%h", bus.sw_out);

        settle("to0F", 8'h0F, 8'h80, 8'h0F, 8'h80);
        settle("toF0", 8'hF0, 8'h0F, 8'hF0, 8'h0F);

        // Bit 3 toggling every cycle never accumulates a full count.
        for (int k = 1; k <= 100; k++) begin
            bus.sw_raw = (k % 2 == 1) ? 8'hF8 : 8'hF0;
            tick();
            chk($sformatf("toggle_c%0d", k), snap(), ev(8'hF0, 8'h00, 8'h00, 1'b0));
        end
        bus.sw_raw = 8'hF0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("toggle_post%0d", k), snap(), ev(8'hF0, 8'h00, 8'h00, 1'b0));
        end
        $display("txn toggle out=%h", bus.sw_out);

        // Reset lands with the pending change at count 2.
        bus.sw_raw = 8'h0F;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("prerst_e%0d", k), snap(), ev(8'hF0, 8'h00, 8'h00, 1'b0));
        end
        #2 rst = 1'b1;
        #1 chk("rst_async", snap(), ev(8'h00, 8'h00, 8'h00, 1'b0));
        tick();
        chk("rst_hold", snap(), ev(8'h00, 8'h00, 8'h00, 1'b0));
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 6)       chk($sformatf("postrst_e%0d", k), snap(), ev(8'h00, 8'h00, 8'h00, 1'b0));
            else if (k == 6) chk($sformatf("postrst_e%0d", k), snap(), ev(8'h0F, 8'h0F, 8'h00, 1'b1));
            else             chk($sformatf("postrst_e%0d", k), snap(), ev(8'h0F, 8'h00, 8'h00, 1'b0));
`ifdef SW_DEBOUNCE_CHG_CNT_EN
            if (k == 6) chk("chgcnt_pulse_cycle", {16'd0, bus.chg_cnt}, 32'd0);
            if (k == 7) chk("chgcnt_one", {16'd0, bus.chg_cnt}, 32'd1);
`endif
        end
        $display("txn postrst out=%h", bus.sw_out);

`ifdef SW_DEBOUNCE_CHG_CNT_EN
        settle("cc_F0", 8'hF0, 8'h0F, 8'hF0, 8'h0F);
        settle("cc_0F", 8'h0F, 8'hF0, 8'h0F, 8'hF0);
        chk("chgcnt_three", {16'd0, bus.chg_cnt}, 32'd3);
        force dut.chg_cnt_q = 16'hFFFF;
        #2 release dut.chg_cnt_q;
        tick();
        chk("chgcnt_preload", {16'd0, bus.chg_cnt}, 32'h0000FFFF);
        settle("cc_wrap", 8'hF0, 8'h0F, 8'hF0, 8'h0F);
        chk("chgcnt_wrap", {16'd0, bus.chg_cnt}, 32'd0);
        $display("txn chg_cnt=%h", bus.chg_cnt);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Upstream conditioning stage for the 8 slide switches; its output drives the priority encoder and segment path in place of raw `sw`.
- Synchronises each asynchronous switch input into `clk` with two flops, then debounces it with a per-bit stability counter.
- Emits the clean switch vector plus one-cycle change, rise and fall event pulses for downstream logic.

Parameters:
- WIDTH, 8, number of switch bits.
- STABLE_CYCLES, 1000000, consecutive cycles a synchronised bit must differ from the output before the output takes it; legal range is ≥2.
- CNT_W, $clog2(STABLE_CYCLES), width of each per-bit counter (derived, not overridden).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- sw_raw  input  WIDTH  raw switch pins, asynchronous to clk.
- sw_out  output  WIDTH  debounced switch vector, registered.
- sw_changed  output  1  one-cycle pulse: some bit of sw_out changed this cycle.
- sw_rise  output  WIDTH  per-bit one-cycle pulse: that bit of sw_out went 0→1.
- sw_fall  output  WIDTH  per-bit one-cycle pulse: that bit of sw_out went 1→0.

Behaviour:
- Reset values: sw_out, sw_changed, sw_rise, sw_fall, both sync stages and all counters are 0.
- Reset is async assert and applies immediately mid-count; any partial count is discarded.
- Synchroniser: sync1 <= sw_raw; sync2 <= sync1. Only sync2 feeds the debounce logic. This adds 2 cycles of latency.
- Per-bit counter cnt[i], with decisions evaluated each clk edge:
  - sync2[i] == sw_out[i]: cnt[i] <= 0.
  - sync2[i] != sw_out[i] and cnt[i] < STABLE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - sync2[i] != sw_out[i] and cnt[i] == STABLE_CYCLES-1: sw_out[i] <= sync2[i]; cnt[i] <= 0.
- Latency: after a clean edge on sw_raw[i], sw_out[i] updates STABLE_CYCLES+2 edges later.
- Glitch rejection: if sync2[i] returns to sw_out[i] before the count completes, the counter clears and sw_out is unchanged. A later disagreement restarts the count from 0.
- Counters never wrap; the maximum value reached is STABLE_CYCLES-1.
- Event pulses are registered in the same edge that updates sw_out, so they are high in exactly the cycle sw_out first shows the new value:
  - sw_rise[i] = (new sw_out[i] == 1) && (old sw_out[i] == 0).
  - sw_fall[i] likewise for 1→0.
  - sw_changed = |(sw_rise | sw_fall).
  - All pulses are 0 in every other cycle.
- Simultaneous events: bits are independent. Several bits may update in one cycle, with several rise/fall bits set and a single sw_changed pulse.
- A bit toggling every cycle never updates sw_out.
- After rst deasserts, a switch already at 1 is seen as a 0→1 change: it produces a rise pulse STABLE_CYCLES+2 cycles later.

Optional Feature:
- Macro: SW_DEBOUNCE_CHG_CNT_EN.
- Defined:
  - Adds output chg_cnt [15:0], reset 0.
  - It increments by 1 on each cycle sw_changed is 1, registered so it is visible the cycle after the pulse.
  - It wraps from 16'hFFFF to 0.
  - This count is the number of debounced change events, not the number of bits that changed.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- STABLE_CYCLES=4 for all cases.
- Reset with sw_raw=8'h00, then hold → sw_out=0, all pulses 0 for 20 cycles.
- Set sw_raw=8'h80 at edge 0 and hold → sw_out=8'h80, sw_rise=8'h80 and sw_changed=1 exactly at edge 6, pulses 0 at edge 7; sw_out stays 8'h80 afterwards.
- sw_out=8'h80; drive sw_raw bit0 high for 3 cycles then low → sw_out stays 8'h80, no pulses. Repeat with a 4-cycle-wide pulse → sw_out=8'h81 with sw_rise=8'h01, then back to 8'h80 with sw_fall=8'h01.
- sw_out=8'h0F; change sw_raw to 8'hF0 in one edge → single cycle with sw_out=8'hF0, sw_rise=8'hF0, sw_fall=8'h0F, sw_changed=1.
- Toggle sw_raw bit3 every cycle for 100 cycles → sw_out[3] unchanged, no pulses. Assert rst at count 2 of a pending change → outputs 0 immediately; after release with sw_raw held, the change is seen 6 cycles later.
- With SW_DEBOUNCE_CHG_CNT_EN: 3 debounced changes → chg_cnt=3. Preload the count to 16'hFFFF via 65535 changes (or force) plus one more change → chg_cnt=0.
